opti_sos_cascade: RTL

OPTI_SOS_CASCADE -- requirements
Module: opti_sos_cascade

---
 rtl/opti_sos_pkg.sv | 20 ++
 rtl/opti_sos_mac.sv | 41 ++++
 rtl/opti_sos_cascade.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/opti_sos_pkg.sv
// Shared types and constants for the time-multiplexed biquad cascade.
package opti_sos_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StRound,
    StOut
  } sos_state_e;

  localparam int unsigned NumTerms = 5;

  // Term order inside a section; also the per-section coefficient offset.
  localparam logic [2:0] B0 = 3'd0;
  localparam logic [2:0] B1 = 3'd1;
  localparam logic [2:0] B2 = 3'd2;
  localparam logic [2:0] A1 = 3'd3;
  localparam logic [2:0] A2 = 3'd4;

endpackage

// File: rtl/opti_sos_mac.sv
// Registered signed multiply feeding an add/subtract accumulator.
// sum presents accumulator plus the pending product so the final term needs no extra cycle.
module opti_sos_mac #(
  parameter int unsigned DW = 24,
  parameter int unsigned CW = 24
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        clr,
  input  logic                        sub,
  input  logic signed [DW-1:0]        a,
  input  logic signed [CW-1:0]        b,
  output logic signed [DW+CW+2:0]     sum
);

  localparam int unsigned AccW = DW + CW + 3;

  logic signed [DW+CW-1:0] prod;
  logic signed [AccW-1:0]  prod_ext;
  logic signed [AccW-1:0]  prod_q;
  logic signed [AccW-1:0]  acc_q;

  always_comb begin
    prod     = a * b;
    prod_ext = {{3{prod[DW+CW-1]}}, prod};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else if (en) begin
      prod_q <= sub ? -prod_ext : prod_ext;
      acc_q  <= clr ? '0 : acc_q + prod_q;
    end
  end

  assign sum = acc_q + prod_q;

endmodule

// File: rtl/opti_sos_cascade.sv
// NSEC direct-form-I biquads in series sharing one multiplier-accumulator.
// Define SOS_SAT_EN to clamp section results and raise sat_flag; otherwise results wrap.
module opti_sos_cascade
  import opti_sos_pkg::*;
#(
  parameter int unsigned DW   = 24,
  parameter int unsigned CW   = 24,
  parameter int unsigned FRAC = 22,
  parameter int unsigned NSEC = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DW-1:0]         data_in,
  input  logic                         valid_in,
  output logic                         ready_in,
  output logic signed [DW-1:0]         data_out,
  output logic                         valid_out,
  input  logic                         coef_we,
  input  logic [$clog2(5*NSEC)-1:0]    coef_addr,
  input  logic signed [CW-1:0]         coef_wdata,
  output logic                         coef_err,
  output logic                         sat_flag
);

  localparam int unsigned NumCoef = NumTerms * NSEC;
  localparam int unsigned AddrW   = $clog2(5 * NSEC);
  localparam int unsigned SecW    = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam int unsigned AccW    = DW + CW + 3;
  localparam logic signed [AccW-1:0] RndHalf = AccW'(1) << (FRAC - 1);

  sos_state_e state_q, state_d;

  logic [2:0]             term_q;
  logic [SecW-1:0]        sec_q;
  logic signed [DW-1:0]   x_cur_q;
  logic signed [CW-1:0]   coef_q [NumCoef];
  logic signed [DW-1:0]   x1_q [NSEC];
  logic signed [DW-1:0]   x2_q [NSEC];
  logic signed [DW-1:0]   y1_q [NSEC];
  logic signed [DW-1:0]   y2_q [NSEC];
  logic signed [DW-1:0]   data_out_q;
  logic                   valid_out_q;
  logic                   coef_err_q;

  logic                   accept;
  logic                   last_sec;
  logic                   coef_ok;
  logic [AddrW-1:0]       coef_idx;
  logic                   mac_en;
  logic                   mac_clr;
  logic                   mac_sub;
  logic signed [DW-1:0]   mac_a;
  logic signed [CW-1:0]   mac_b;
  logic signed [AccW-1:0] mac_sum;
  logic signed [AccW-1:0] shifted;
  logic signed [DW-1:0]   res;

  assign accept   = valid_in & ready_in;
  assign last_sec = (32'(sec_q) == NSEC - 1);
  assign coef_ok  = coef_we && (state_q == StIdle) && (32'(coef_addr) < NumCoef);
  assign coef_idx = AddrW'(NumTerms * 32'(sec_q) + 32'(term_q));
  assign mac_b    = coef_q[coef_idx];
  assign shifted  = (mac_sum + RndHalf) >>> FRAC;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StMac;
      StMac:   if (term_q == A2) state_d = StRound;
      StRound: state_d = last_sec ? StOut : StMac;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs and MAC operand selection
  always_comb begin
    ready_in = (state_q == StIdle);
    mac_en   = (state_q == StMac);
    mac_clr  = (term_q == B0);
    mac_sub  = (term_q == A1) || (term_q == A2);
    case (term_q)
      B1:      mac_a = x1_q[sec_q];
      B2:      mac_a = x2_q[sec_q];
      A1:      mac_a = y1_q[sec_q];
      A2:      mac_a = y2_q[sec_q];
      default: mac_a = x_cur_q;
    endcase
  end

  opti_sos_mac #(
    .DW (DW),
    .CW (CW)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mac_en),
    .clr   (mac_clr),
    .sub   (mac_sub),
    .a     (mac_a),
    .b     (mac_b),
    .sum   (mac_sum)
  );

`ifdef SOS_SAT_EN
  logic sat_q;
  logic clamp;

  // Out of range when the bits above the DW-bit sign are not a pure sign extension.
  always_comb begin
    clamp = !((&shifted[AccW-1:DW-1]) || !(|shifted[AccW-1:DW-1]));
    res   = shifted[DW-1:0];
    if (clamp) begin
      res = shifted[AccW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if ((state_q == StRound) && clamp) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_flag = sat_q;
`else
  assign res      = shifted[DW-1:0];
  assign sat_flag = 1'b0;
`endif

  // Sequencing counters, delay lines and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term_q      <= B0;
      sec_q       <= '0;
      x_cur_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      for (int i = 0; i < int'(NSEC); i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      valid_out_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            term_q  <= B0;
            sec_q   <= '0;
            x_cur_q <= data_in;
          end
        end
        StMac: begin
          term_q <= (term_q == A2) ? B0 : term_q + 3'd1;
        end
        StRound: begin
          x2_q[sec_q] <= x1_q[sec_q];
          x1_q[sec_q] <= x_cur_q;
          y2_q[sec_q] <= y1_q[sec_q];
          y1_q[sec_q] <= res;
          x_cur_q     <= res;
          if (!last_sec) sec_q <= sec_q + 1'b1;
        end
        StOut: begin
          data_out_q  <= x_cur_q;
          valid_out_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Coefficient bank; writes are only safe while no sample is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_err_q <= 1'b0;
      for (int i = 0; i < int'(NumCoef); i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      coef_err_q <= coef_we & ~coef_ok;
      if (coef_ok) coef_q[coef_addr] <= coef_wdata;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign coef_err  = coef_err_q;

endmodule
